// File: rtl/dma_inter_mux.sv
// Multi-channel AXI-stream to DMA FIFO packer with packet-aligned channel switching.
// Optional statistics (transfer_cnt, drop_cnt, ovf_sticky) are compiled in with DMA_INTER_MUX_STATS_EN.
module dma_inter_mux #(
    parameter int NUM_CH    = 4,
    parameter int IN_WIDTH  = 32,
    parameter int OUT_WIDTH = 64,
    parameter int CNT_WIDTH = 32,
    localparam int SEL_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                       rx_link_clk,
    input  logic                       rst_n,
    input  logic                       enable,
    input  logic [SEL_W-1:0]           ch_sel,
    input  logic [NUM_CH*IN_WIDTH-1:0] s_axis_tdata,
    input  logic [NUM_CH-1:0]          s_axis_tvalid,
    input  logic [NUM_CH-1:0]          s_axis_tlast,
    output logic [NUM_CH-1:0]          s_axis_tready,
    output logic                       fifo_wr_en,
    output logic                       fifo_wr_sync,
    output logic [OUT_WIDTH-1:0]       fifo_wr_data,
    input  logic                       fifo_wr_xfer_req,
    input  logic                       fifo_wr_overflow,
    output logic [SEL_W-1:0]           active_ch,
    output logic [1:0]                 state,
    output logic                       ovf_sticky,
    output logic [CNT_WIDTH-1:0]       transfer_cnt,
    output logic [CNT_WIDTH-1:0]       drop_cnt
);

    localparam int RATIO = OUT_WIDTH / IN_WIDTH;
    localparam int BC_W  = (RATIO > 1) ? $clog2(RATIO) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SYNC   = 2'd1,
        ACTIVE = 2'd2,
        FLUSH  = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [SEL_W-1:0]     active_ch_q, active_ch_d;
    logic [BC_W-1:0]      beat_cnt_q, beat_cnt_d;
    logic [OUT_WIDTH-1:0] pack_q, pack_d;
    logic                 sop_q, sop_d;
    logic                 wr_en_q, wr_en_d;
    logic                 wr_sync_q, wr_sync_d;
    logic [OUT_WIDTH-1:0] wr_data_q, wr_data_d;
    logic [CNT_WIDTH-1:0] drop_inc;

    logic                 beat_vld;
    logic                 beat_last;
    logic [IN_WIDTH-1:0]  beat_data;
    logic [OUT_WIDTH-1:0] lane_word;
    logic [SEL_W-1:0]     sel_eff;
    logic                 go;

    // No backpressure exists towards the sources.
    assign s_axis_tready = '1;

    assign sel_eff = (NUM_CH == 1) ? '0 : ch_sel;
    assign go      = enable & fifo_wr_xfer_req;

    always_comb begin
        beat_vld  = 1'b0;
        beat_last = 1'b0;
        beat_data = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (active_ch_q == SEL_W'(k)) begin
                beat_vld  = s_axis_tvalid[k];
                beat_last = s_axis_tlast[k];
                beat_data = s_axis_tdata[k*IN_WIDTH +: IN_WIDTH];
            end
        end
    end

    always_comb begin
        lane_word = pack_q;
        lane_word[beat_cnt_q*IN_WIDTH +: IN_WIDTH] = beat_data;
    end

    always_comb begin
        state_d     = state_q;
        active_ch_d = active_ch_q;
        beat_cnt_d  = beat_cnt_q;
        pack_d      = pack_q;
        sop_d       = sop_q;
        wr_en_d     = 1'b0;
        wr_sync_d   = 1'b0;
        wr_data_d   = wr_data_q;
        drop_inc    = '0;

        case (state_q)
            IDLE: begin
                if (beat_vld) drop_inc = CNT_WIDTH'(1);
                if (go) begin
                    state_d     = SYNC;
                    active_ch_d = sel_eff;
                    beat_cnt_d  = '0;
                    pack_d      = '0;
                end
            end
            SYNC: begin
                if (beat_vld) drop_inc = CNT_WIDTH'(1);
                if (!go) begin
                    state_d = IDLE;
                end else if (beat_vld && beat_last) begin
                    state_d = ACTIVE;
                    sop_d   = 1'b1;
                end
            end
            ACTIVE: begin
                if (!go) begin
                    // Partial word is thrown away; every beat it held counts as dropped.
                    state_d    = IDLE;
                    drop_inc   = CNT_WIDTH'(beat_cnt_q) + CNT_WIDTH'(beat_vld);
                    beat_cnt_d = '0;
                    pack_d     = '0;
                end else if (beat_vld) begin
                    if (beat_last || beat_cnt_q == BC_W'(RATIO - 1)) begin
                        wr_en_d    = 1'b1;
                        wr_sync_d  = sop_q;
                        wr_data_d  = lane_word;
                        sop_d      = beat_last;
                        beat_cnt_d = '0;
                        pack_d     = '0;
                        if (beat_last && sel_eff != active_ch_q) state_d = FLUSH;
                    end else begin
                        pack_d     = lane_word;
                        beat_cnt_d = beat_cnt_q + BC_W'(1);
                    end
                end
            end
            FLUSH: begin
                if (!go) begin
                    state_d    = IDLE;
                    drop_inc   = CNT_WIDTH'(beat_cnt_q) + CNT_WIDTH'(beat_vld);
                    beat_cnt_d = '0;
                    pack_d     = '0;
                end else begin
                    if (beat_cnt_q != '0) begin
                        wr_en_d    = 1'b1;
                        wr_sync_d  = sop_q;
                        wr_data_d  = pack_q;
                        beat_cnt_d = '0;
                        pack_d     = '0;
                    end
                    active_ch_d = sel_eff;
                    state_d     = ACTIVE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge rx_link_clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            active_ch_q <= '0;
            beat_cnt_q  <= '0;
            pack_q      <= '0;
            sop_q       <= 1'b0;
            wr_en_q     <= 1'b0;
            wr_sync_q   <= 1'b0;
            wr_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            active_ch_q <= active_ch_d;
            beat_cnt_q  <= beat_cnt_d;
            pack_q      <= pack_d;
            sop_q       <= sop_d;
            wr_en_q     <= wr_en_d;
            wr_sync_q   <= wr_sync_d;
            wr_data_q   <= wr_data_d;
        end
    end

    assign fifo_wr_en   = wr_en_q;
    assign fifo_wr_sync = wr_sync_q;
    assign fifo_wr_data = wr_data_q;
    assign active_ch    = active_ch_q;
    assign state        = state_q;

`ifdef DMA_INTER_MUX_STATS_EN
    logic [CNT_WIDTH-1:0] transfer_cnt_q, transfer_cnt_d;
    logic [CNT_WIDTH-1:0] drop_cnt_q, drop_cnt_d;
    logic                 ovf_q, ovf_d;

    // transfer_cnt advances in the same cycle fifo_wr_en is presented.
    always_comb begin
        transfer_cnt_d = transfer_cnt_q + CNT_WIDTH'(wr_en_d);
        drop_cnt_d     = drop_cnt_q + drop_inc;
        ovf_d          = enable ? (ovf_q | fifo_wr_overflow) : 1'b0;
    end

    always_ff @(posedge rx_link_clk) begin
        if (!rst_n) begin
            transfer_cnt_q <= '0;
            drop_cnt_q     <= '0;
            ovf_q          <= 1'b0;
        end else begin
            transfer_cnt_q <= transfer_cnt_d;
            drop_cnt_q     <= drop_cnt_d;
            ovf_q          <= ovf_d;
        end
    end

    assign transfer_cnt = transfer_cnt_q;
    assign drop_cnt     = drop_cnt_q;
    assign ovf_sticky   = ovf_q;
`else
    logic unused_stats;
    assign unused_stats = ^{drop_inc, fifo_wr_overflow};
    assign transfer_cnt = '0;
    assign drop_cnt     = '0;
    assign ovf_sticky   = 1'b0;
`endif

endmodule

// File: tb/tb_dma_inter_mux.sv
// Directed self-checking bench for dma_inter_mux at default parameters (4 ch, 32->64 bit).
module tb_dma_inter_mux;

`ifdef DMA_INTER_MUX_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic         rx_link_clk;
    logic         rst_n;
    logic         enable;
    logic [1:0]   ch_sel;
    logic [127:0] s_axis_tdata;
    logic [3:0]   s_axis_tvalid;
    logic [3:0]   s_axis_tlast;
    logic [3:0]   s_axis_tready;
    logic         fifo_wr_en;
    logic         fifo_wr_sync;
    logic [63:0]  fifo_wr_data;
    logic         fifo_wr_xfer_req;
    logic         fifo_wr_overflow;
    logic [1:0]   active_ch;
    logic [1:0]   state;
    logic         ovf_sticky;
    logic [31:0]  transfer_cnt;
    logic [31:0]  drop_cnt;

    int checks;
    int errors;

    dma_inter_mux dut (
        .rx_link_clk      (rx_link_clk),
        .rst_n            (rst_n),
        .enable           (enable),
        .ch_sel           (ch_sel),
        .s_axis_tdata     (s_axis_tdata),
        .s_axis_tvalid    (s_axis_tvalid),
        .s_axis_tlast     (s_axis_tlast),
        .s_axis_tready    (s_axis_tready),
        .fifo_wr_en       (fifo_wr_en),
        .fifo_wr_sync     (fifo_wr_sync),
        .fifo_wr_data     (fifo_wr_data),
        .fifo_wr_xfer_req (fifo_wr_xfer_req),
        .fifo_wr_overflow (fifo_wr_overflow),
        .active_ch        (active_ch),
        .state            (state),
        .ovf_sticky       (ovf_sticky),
        .transfer_cnt     (transfer_cnt),
        .drop_cnt         (drop_cnt)
    );

    initial rx_link_clk = 1'b0;
    always #5 rx_link_clk = ~rx_link_clk;

    task automatic tick();
        @(posedge rx_link_clk);
        #1;
    endtask

    task automatic beat(input int ch, input logic [31:0] d, input logic last);
        s_axis_tvalid = '0;
        s_axis_tlast  = '0;
        s_axis_tvalid[ch] = 1'b1;
        s_axis_tlast[ch]  = last;
        s_axis_tdata[ch*32 +: 32] = d;
        tick();
        s_axis_tvalid = '0;
        s_axis_tlast  = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        checks++;
        if (state !== 2'd0 || active_ch !== 2'd0) begin
            errors++;
            $display("FAIL reset_state: state=%0d active_ch=%0d, need 0/0", state, active_ch);
        end
        checks++;
        if (fifo_wr_en !== 1'b0 || fifo_wr_sync !== 1'b0 || fifo_wr_data !== 64'h0) begin
            errors++;
            $display("FAIL reset_fifo: en=%b sync=%b data=%h, need 0", fifo_wr_en, fifo_wr_sync, fifo_wr_data);
        end
        checks++;
        if (transfer_cnt !== 32'd0 || drop_cnt !== 32'd0 || ovf_sticky !== 1'b0) begin
            errors++;
            $display("FAIL reset_stats: xfer=%0d drop=%0d ovf=%b, need 0", transfer_cnt, drop_cnt, ovf_sticky);
        end
        checks++;
        if (s_axis_tready !== 4'hF) begin
            errors++;
            $display("FAIL tready: got %h need f", s_axis_tready);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_basic_pack();
        enable = 1'b1;
        fifo_wr_xfer_req = 1'b1;
        ch_sel = 2'd1;
        tick();
        checks++;
        if (state !== 2'd1 || active_ch !== 2'd1) begin
            errors++;
            $display("FAIL enter_sync: state=%0d ch=%0d, need 1/1", state, active_ch);
        end
        beat(1, 32'h99, 1'b1);
        checks++;
        if (state !== 2'd2 || drop_cnt !== (STATS ? 32'd1 : 32'd0)) begin
            errors++;
            $display("FAIL sync_done: state=%0d drop=%0d, need 2/%0d", state, drop_cnt, STATS ? 1 : 0);
        end
        beat(1, 32'h11, 1'b0);
        checks++;
        if (fifo_wr_en !== 1'b0) begin
            errors++;
            $display("FAIL half_word: wr_en=%b need 0", fifo_wr_en);
        end
        beat(1, 32'h22, 1'b0);
        checks++;
        if (fifo_wr_en !== 1'b1 || fifo_wr_sync !== 1'b1 || fifo_wr_data !== 64'h00000022_00000011) begin
            errors++;
            $display("FAIL word0: en=%b sync=%b data=%h, need 1/1/0000002200000011", fifo_wr_en, fifo_wr_sync, fifo_wr_data);
        end
        beat(1, 32'h33, 1'b0);
        checks++;
        if (fifo_wr_en !== 1'b0) begin
            errors++;
            $display("FAIL wr_en_pulse: wr_en=%b need 0", fifo_wr_en);
        end
        beat(1, 32'h44, 1'b1);
        checks++;
        if (fifo_wr_en !== 1'b1 || fifo_wr_sync !== 1'b0 || fifo_wr_data !== 64'h00000044_00000033) begin
            errors++;
            $display("FAIL word1: en=%b sync=%b data=%h, need 1/0/0000004400000033", fifo_wr_en, fifo_wr_sync, fifo_wr_data);
        end
        checks++;
        if (transfer_cnt !== (STATS ? 32'd2 : 32'd0) || state !== 2'd2) begin
            errors++;
            $display("FAIL basic_cnt: xfer=%0d state=%0d, need %0d/2", transfer_cnt, state, STATS ? 2 : 0);
        end
    endtask

    task automatic test_padding();
        beat(1, 32'hA, 1'b0);
        beat(1, 32'hB, 1'b0);
        checks++;
        if (fifo_wr_en !== 1'b1 || fifo_wr_sync !== 1'b1 || fifo_wr_data !== 64'h0000000B_0000000A) begin
            errors++;
            $display("FAIL pad_word0: en=%b sync=%b data=%h, need 1/1/0000000b0000000a", fifo_wr_en, fifo_wr_sync, fifo_wr_data);
        end
        beat(1, 32'hC, 1'b1);
        checks++;
        if (fifo_wr_en !== 1'b1 || fifo_wr_sync !== 1'b0 || fifo_wr_data !== 64'h00000000_0000000C) begin
            errors++;
            $display("FAIL pad_word1: en=%b sync=%b data=%h, need 1/0/000000000000000c", fifo_wr_en, fifo_wr_sync, fifo_wr_data);
        end
        tick();
        checks++;
        if (fifo_wr_en !== 1'b0 || transfer_cnt !== (STATS ? 32'd4 : 32'd0)) begin
            errors++;
            $display("FAIL pad_after: en=%b xfer=%0d, need 0/%0d", fifo_wr_en, transfer_cnt, STATS ? 4 : 0);
        end
    endtask

    task automatic test_switch();
        ch_sel = 2'd0;
        beat(1, 32'h5, 1'b1);
        checks++;
        if (fifo_wr_en !== 1'b1 || fifo_wr_data !== 64'h5 || state !== 2'd3) begin
            errors++;
            $display("FAIL to_flush: en=%b data=%h state=%0d, need 1/5/3", fifo_wr_en, fifo_wr_data, state);
        end
        tick();
        checks++;
        if (state !== 2'd2 || active_ch !== 2'd0) begin
            errors++;
            $display("FAIL flush_done: state=%0d ch=%0d, need 2/0", state, active_ch);
        end
        beat(0, 32'h100, 1'b0);
        ch_sel = 2'd2;
        beat(0, 32'h101, 1'b0);
        checks++;
        if (fifo_wr_en !== 1'b1 || fifo_wr_sync !== 1'b1 || fifo_wr_data !== 64'h00000101_00000100 || active_ch !== 2'd0) begin
            errors++;
            $display("FAIL mid_switch: en=%b sync=%b data=%h ch=%0d, need 1/1/0000010100000100/0", fifo_wr_en, fifo_wr_sync, fifo_wr_data, active_ch);
        end
        beat(0, 32'h102, 1'b1);
        checks++;
        if (fifo_wr_en !== 1'b1 || fifo_wr_data !== 64'h00000000_00000102 || state !== 2'd3) begin
            errors++;
            $display("FAIL switch_last: en=%b data=%h state=%0d, need 1/0000000000000102/3", fifo_wr_en, fifo_wr_data, state);
        end
        beat(0, 32'h1FF, 1'b0);
        checks++;
        if (state !== 2'd2 || active_ch !== 2'd2 || fifo_wr_en !== 1'b0) begin
            errors++;
            $display("FAIL switch_ch2: state=%0d ch=%0d en=%b, need 2/2/0", state, active_ch, fifo_wr_en);
        end
        beat(0, 32'h1EE, 1'b0);
        beat(2, 32'h200, 1'b0);
        beat(2, 32'h201, 1'b0);
        checks++;
        if (fifo_wr_en !== 1'b1 || fifo_wr_sync !== 1'b1 || fifo_wr_data !== 64'h00000201_00000200) begin
            errors++;
            $display("FAIL ch2_word: en=%b sync=%b data=%h, need 1/1/0000020100000200", fifo_wr_en, fifo_wr_sync, fifo_wr_data);
        end
        checks++;
        if (drop_cnt !== (STATS ? 32'd1 : 32'd0) || transfer_cnt !== (STATS ? 32'd8 : 32'd0)) begin
            errors++;
            $display("FAIL switch_cnt: drop=%0d xfer=%0d, need %0d/%0d", drop_cnt, transfer_cnt, STATS ? 1 : 0, STATS ? 8 : 0);
        end
    endtask

    task automatic test_abort();
        beat(2, 32'h300, 1'b0);
        fifo_wr_xfer_req = 1'b0;
        tick();
        checks++;
        if (state !== 2'd0 || fifo_wr_en !== 1'b0 || drop_cnt !== (STATS ? 32'd2 : 32'd0)) begin
            errors++;
            $display("FAIL abort: state=%0d en=%b drop=%0d, need 0/0/%0d", state, fifo_wr_en, drop_cnt, STATS ? 2 : 0);
        end
        fifo_wr_xfer_req = 1'b1;
        tick();
        beat(2, 32'h3FF, 1'b1);
        beat(2, 32'h400, 1'b0);
        fifo_wr_xfer_req = 1'b0;
        beat(2, 32'h401, 1'b0);
        checks++;
        if (state !== 2'd0 || fifo_wr_en !== 1'b0 || drop_cnt !== (STATS ? 32'd5 : 32'd0)) begin
            errors++;
            $display("FAIL abort_beat: state=%0d en=%b drop=%0d, need 0/0/%0d", state, fifo_wr_en, drop_cnt, STATS ? 5 : 0);
        end
        beat(2, 32'h402, 1'b0);
        checks++;
        if (state !== 2'd0 || drop_cnt !== (STATS ? 32'd6 : 32'd0) || transfer_cnt !== (STATS ? 32'd8 : 32'd0)) begin
            errors++;
            $display("FAIL idle_drop: state=%0d drop=%0d xfer=%0d, need 0/%0d/%0d", state, drop_cnt, transfer_cnt, STATS ? 6 : 0, STATS ? 8 : 0);
        end
    endtask

    task automatic test_overflow();
        fifo_wr_overflow = 1'b1;
        tick();
        fifo_wr_overflow = 1'b0;
        tick();
        checks++;
        if (ovf_sticky !== STATS) begin
            errors++;
            $display("FAIL ovf_hold: got %b need %b", ovf_sticky, STATS);
        end
        enable = 1'b0;
        tick();
        checks++;
        if (ovf_sticky !== 1'b0) begin
            errors++;
            $display("FAIL ovf_clear: got %b need 0", ovf_sticky);
        end
        fifo_wr_overflow = 1'b1;
        tick();
        checks++;
        if (ovf_sticky !== 1'b0) begin
            errors++;
            $display("FAIL ovf_clear_wins: got %b need 0", ovf_sticky);
        end
        fifo_wr_overflow = 1'b0;
        enable = 1'b1;
    endtask

    task automatic test_reset_midword();
        fifo_wr_xfer_req = 1'b1;
        ch_sel = 2'd1;
        tick();
        beat(1, 32'h77, 1'b1);
        beat(1, 32'h55, 1'b0);
        rst_n = 1'b0;
        tick();
        checks++;
        if (state !== 2'd0 || active_ch !== 2'd0 || fifo_wr_en !== 1'b0 || fifo_wr_sync !== 1'b0 || fifo_wr_data !== 64'h0) begin
            errors++;
            $display("FAIL midword_reset: state=%0d ch=%0d en=%b sync=%b data=%h, need all 0", state, active_ch, fifo_wr_en, fifo_wr_sync, fifo_wr_data);
        end
        checks++;
        if (transfer_cnt !== 32'd0 || drop_cnt !== 32'd0 || ovf_sticky !== 1'b0) begin
            errors++;
            $display("FAIL midword_stats: xfer=%0d drop=%0d ovf=%b, need 0", transfer_cnt, drop_cnt, ovf_sticky);
        end
        rst_n = 1'b1;
        fifo_wr_xfer_req = 1'b0;
        tick();
        checks++;
        if (fifo_wr_en !== 1'b0 || state !== 2'd0) begin
            errors++;
            $display("FAIL post_reset: en=%b state=%0d, need 0/0", fifo_wr_en, state);
        end
    endtask

    initial begin
        checks           = 0;
        errors           = 0;
        rst_n            = 1'b0;
        enable           = 1'b0;
        ch_sel           = 2'd0;
        s_axis_tdata     = '0;
        s_axis_tvalid    = '0;
        s_axis_tlast     = '0;
        fifo_wr_xfer_req = 1'b0;
        fifo_wr_overflow = 1'b0;
        test_reset();
        test_basic_pack();
        test_padding();
        test_switch();
        test_abort();
        test_overflow();
        test_reset_midword();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dma_inter_mux.md
DMA_INTER_MUX -- requirements
Module: dma_inter_mux

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of single-clock AXI-stream source channels (1..8).
REQ-002 SHALL have parameter IN_WIDTH, default 32, per-channel tdata width.
REQ-003 SHALL have parameter OUT_WIDTH, default 64, DMA write width; OUT_WIDTH = RATIO*IN_WIDTH, where RATIO is a power of 2 in 1..8.
REQ-004 SHALL have parameter CNT_WIDTH, default 32, statistics counter width.
REQ-005 SHALL have the following ports, one per line: name, direction, width, meaning.
- rx_link_clk  in  1  sole clock.
- rst_n  in  1  synchronous, active-low reset.
- enable  in  1  block enable.
- ch_sel  in  max(1,clog2(NUM_CH))  requested source channel.
- s_axis_tdata  in  NUM_CH*IN_WIDTH  channel data; channel k occupies bits [k*IN_WIDTH +: IN_WIDTH].
- s_axis_tvalid  in  NUM_CH  per-channel valid.
- s_axis_tlast  in  NUM_CH  per-channel end of packet.
- s_axis_tready  out  NUM_CH  per-channel ready.
- fifo_wr_en  out  1  DMA write strobe.
- fifo_wr_sync  out  1  first word of packet.
- fifo_wr_data  out  OUT_WIDTH  DMA write data.
- fifo_wr_xfer_req  in  1  DMA transfer request.
- fifo_wr_overflow  in  1  DMA FIFO overflow.
- active_ch  out  max(1,clog2(NUM_CH))  channel currently latched.
- state  out  2  FSM state code.
- ovf_sticky  out  1  latched overflow.
- transfer_cnt  out  CNT_WIDTH  written words.
- drop_cnt  out  CNT_WIDTH  discarded input beats.

Function
REQ-006 s_axis_tready SHALL be all-ones in every state, since the DMA path has no backpressure; a beat is accepted when tvalid is high.
REQ-007 The FSM SHALL have the states IDLE=0, SYNC=1, ACTIVE=2, FLUSH=3.
REQ-008 IDLE->SYNC SHALL occur when enable & fifo_wr_xfer_req, and active_ch SHALL load ch_sel on that transition.
REQ-009 SYNC SHALL discard beats of active_ch until one with tlast, then go to ACTIVE, so that the next beat is a start of packet.
REQ-010 ACTIVE SHALL pack beats of active_ch LSB-first, with beat 0 in bits [IN_WIDTH-1:0], and a word SHALL complete after RATIO beats.
REQ-011 fifo_wr_en SHALL pulse for 1 cycle, registered, one cycle after the cycle accepting the completing beat.
REQ-012 tlast in ACTIVE with fewer than RATIO beats packed SHALL complete the word immediately, zero-padding the unfilled upper lanes.
REQ-013 fifo_wr_sync SHALL be high together with fifo_wr_en on the first word after every start of packet, and low otherwise.
REQ-014 ACTIVE->FLUSH SHALL occur on an accepted tlast beat when ch_sel != active_ch.
REQ-015 FLUSH SHALL emit any pending word, load active_ch from ch_sel, and go to ACTIVE on the next cycle; no resync is needed because the boundary is known.
REQ-016 A ch_sel change mid-packet SHALL be ignored until that packet's tlast.
REQ-017 Beats on channels other than active_ch SHALL be discarded and SHALL not be counted.
REQ-018 fifo_wr_xfer_req low or enable low in SYNC, ACTIVE or FLUSH SHALL send the FSM to IDLE the next cycle.
- Any partial word SHALL be discarded and SHALL not be written.
- The beats held in the discarded word SHALL be added to drop_cnt.
REQ-019 A beat accepted on active_ch in the same cycle as that xfer_req drop SHALL be discarded and counted in drop_cnt.
REQ-020 Beats on active_ch accepted in IDLE or SYNC SHALL increment drop_cnt by 1 each.
REQ-021 transfer_cnt SHALL increment by 1 per fifo_wr_en, and both counters SHALL wrap modulo 2^CNT_WIDTH.
REQ-022 ovf_sticky SHALL set on fifo_wr_overflow=1 and SHALL clear only when enable=0 or on reset; if both occur in the same cycle, clear SHALL win.
REQ-023 With NUM_CH=1, ch_sel SHALL be ignored and active_ch SHALL be 0.

Reset
REQ-024 While rst_n=0 at a rising edge of rx_link_clk, the block SHALL reset to:
- state IDLE.
- active_ch 0, ovf_sticky 0.
- packer beat count 0, packer data 0.
- fifo_wr_en 0, fifo_wr_sync 0, fifo_wr_data 0.
- transfer_cnt 0, drop_cnt 0.
REQ-025 A reset mid-packet SHALL abandon the partial word without emitting it.

Configuration
REQ-026 Macro DMA_INTER_MUX_STATS_EN defined SHALL compile in transfer_cnt, drop_cnt and ovf_sticky as specified above.
REQ-027 Macro DMA_INTER_MUX_STATS_EN undefined SHALL tie those three outputs to 0 and SHALL remove their registers; all other behaviour SHALL be identical.

Verification
REQ-028 Basic packing: defaults, ch_sel=1, xfer_req=1, one 1-beat packet to sync, then 4 beats 0x11,0x22,0x33,0x44 with tlast on 0x44 -> 2 words 0x00000022_00000011 (sync=1) and 0x00000044_00000033 (sync=0); transfer_cnt=2.
REQ-029 Padding: 3-beat packet 0xA,0xB,0xC with tlast -> words 0x0B_0A and 0x00_0C, where 0x00 is the zero-padded upper lane, and the last word appears 1 cycle after tlast.
REQ-030 Switch: ch_sel 0->2 mid-packet -> remaining ch0 beats packed until tlast, then FLUSH, and the next word comes from ch2 with sync=1; ch0 beats after tlast are not counted.
REQ-031 Abort: xfer_req drops after 1 beat of a word -> no fifo_wr_en, drop_cnt +1, FSM in IDLE next cycle.
REQ-032 Stats/reset: fifo_wr_overflow pulse -> ovf_sticky=1 until enable=0; rst_n=0 mid-word -> all outputs 0 the next cycle; with DMA_INTER_MUX_STATS_EN undefined, the counters stay 0.
